// File: rtl/eviction_write_buffer_nway.sv
// Eviction write buffer between the L2 pmem port and physical memory.
// DEPTH-entry circular FIFO of dirty lines. It drains to pmem one line at a
// time and forwards buffered lines to L2 miss reads.
// Optional build macro EWB_COALESCE_EN: a push that hits a buffered line
// overwrites that line in place. The head line is excluded while it is
// being written.

// Per-entry tag comparator. It ignores the line-offset bits, which the
// caller strips before connecting.
module ewb_tag_cmp #(
  parameter int TAG_W = 27
) (
  input  logic             vld,
  input  logic [TAG_W-1:0] tag_a,
  input  logic [TAG_W-1:0] tag_b,
  output logic             match
);
  assign match = vld & (tag_a == tag_b);
endmodule

module eviction_write_buffer_nway #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       evict_valid,
  input  logic [ADDR_W-1:0]          evict_addr,
  input  logic [LINE_W-1:0]          evict_data,
  output logic                       evict_ready,
  input  logic                       rd_req,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic                       rd_hit,
  output logic [LINE_W-1:0]          rd_hit_data,
  input  logic                       pmem_rd_busy,
  input  logic                       flush,
  output logic                       pmem_write,
  output logic [ADDR_W-1:0]          pmem_address,
  output logic [LINE_W-1:0]          pmem_wdata,
  input  logic                       pmem_resp,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int OFS   = $clog2(LINE_W/8);
  localparam int TAG_W = ADDR_W - OFS;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_WRITE = 1'b1;

  logic [DEPTH-1:0]             ent_vld;
  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr;
  logic [DEPTH-1:0][LINE_W-1:0] ent_data;
  logic [PW-1:0]                head, tail;
  logic [CW-1:0]                cnt;
  logic [0:0]                   st;

  logic [DEPTH-1:0] rd_m;
  logic             rd_hit_c;
  logic [PW-1:0]    rd_sel, rd_idx;
  logic             co_hit;
  logic             push, alloc, pop;

  // rd_req only qualifies the L2's own use of rd_hit; low address bits are don't-care
  logic unused_sink;
  assign unused_sink = &{1'b0, rd_req, rd_addr[OFS-1:0]};

  // One read-forwarding comparator per entry
  for (genvar g = 0; g < DEPTH; g++) begin : g_rd_cmp
    ewb_tag_cmp #(.TAG_W(TAG_W)) u_rd_cmp (
      .vld   (ent_vld[g]),
      .tag_a (ent_addr[g][ADDR_W-1:OFS]),
      .tag_b (rd_addr[ADDR_W-1:OFS]),
      .match (rd_m[g])
    );
  end

  // Walk oldest->newest so the newest matching entry is the last one kept
  always_comb begin
    rd_hit_c = 1'b0;
    rd_sel   = '0;
    rd_idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      rd_idx = head + PW'(k);
      if (rd_m[rd_idx]) begin
        rd_hit_c = 1'b1;
        rd_sel   = rd_idx;
      end
    end
  end

`ifdef EWB_COALESCE_EN
  logic [DEPTH-1:0] ev_m;
  logic [PW-1:0]    co_sel, co_idx;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ev_cmp
    ewb_tag_cmp #(.TAG_W(TAG_W)) u_ev_cmp (
      .vld   (ent_vld[g]),
      .tag_a (ent_addr[g][ADDR_W-1:OFS]),
      .tag_b (evict_addr[ADDR_W-1:OFS]),
      .match (ev_m[g])
    );
  end

  // Newest coalesce target; the head line being written must stay stable
  always_comb begin
    co_hit = 1'b0;
    co_sel = '0;
    co_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      co_idx = head + PW'(k);
      if (ev_m[co_idx] && !(co_idx == head && st == ST_WRITE)) begin
        co_hit = 1'b1;
        co_sel = co_idx;
      end
    end
  end
`else
  assign co_hit = 1'b0;
`endif

  // Ready comes from the registered count only, so a same-cycle pop never frees a slot early
  assign evict_ready = rst | (cnt < CW'(DEPTH)) | co_hit;
  assign push        = evict_valid & evict_ready & ~rst;
  assign alloc       = push & ~co_hit;
  assign pop         = (st == ST_WRITE) & pmem_resp;

  assign pmem_write   = ~rst & (st == ST_WRITE);
  assign pmem_address = ent_addr[head];
  assign pmem_wdata   = ent_data[head];
  assign rd_hit       = ~rst & rd_hit_c;
  assign rd_hit_data  = rd_hit ? ent_data[rd_sel] : '0;
  assign empty        = rst | (cnt == '0);
  assign count        = rst ? '0 : cnt;

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_vld <= '0;
      head    <= '0;
      tail    <= '0;
      cnt     <= '0;
    end else begin
      if (pop) begin
        ent_vld[head] <= 1'b0;
        head          <= head + 1'b1;
      end
      if (alloc) begin
        ent_vld[tail]  <= 1'b1;
        ent_addr[tail] <= evict_addr;
        ent_data[tail] <= evict_data;
        tail           <= tail + 1'b1;
      end
`ifdef EWB_COALESCE_EN
      if (push && co_hit)
        ent_data[co_sel] <= evict_data;
`endif
      cnt <= cnt + CW'(alloc) - CW'(pop);
    end
  end

  // Drain FSM: one line per WRITE; after each completion it spends at least one cycle in IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= ST_IDLE;
    end else begin
      case (st)
        ST_IDLE:  if (cnt != '0 && (!pmem_rd_busy || flush)) st <= ST_WRITE;
        ST_WRITE: if (pmem_resp) st <= ST_IDLE;
        default:  st <= ST_IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  // A push offered while not ready is dropped; flag it as an L2 protocol error
  always @(posedge clk)
    if (!rst)
      assert (!(evict_valid && !evict_ready))
        else $warning("ewb: evict_valid while not ready, line dropped");
`endif

endmodule

// File: tb/tb_eviction_write_buffer_nway.sv
// Bench for eviction_write_buffer_nway: directed scenarios plus random
// traffic, all checked against a queue-based reference model.
module tb_eviction_write_buffer_nway;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              evict_valid = 1'b0;
  logic [ADDR_W-1:0] evict_addr = '0;
  logic [LINE_W-1:0] evict_data = '0;
  logic              evict_ready;
  logic              rd_req = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              rd_hit;
  logic [LINE_W-1:0] rd_hit_data;
  logic              pmem_rd_busy = 1'b0;
  logic              flush = 1'b0;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic              pmem_resp = 1'b0;
  logic              empty;
  logic [$clog2(DEPTH):0] count;

  eviction_write_buffer_nway #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .evict_valid(evict_valid), .evict_addr(evict_addr), .evict_data(evict_data),
    .evict_ready(evict_ready),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_hit(rd_hit), .rd_hit_data(rd_hit_data),
    .pmem_rd_busy(pmem_rd_busy), .flush(flush),
    .pmem_write(pmem_write), .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [255:0] got, logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: the FIFO contents as a queue, plus whether a drain write is in flight
  typedef struct { logic [ADDR_W-1:0] a; logic [LINE_W-1:0] d; } ent_t;
  ent_t q[$];
  bit   in_wr = 0;

  function automatic bit same_line(logic [ADDR_W-1:0] x, logic [ADDR_W-1:0] y);
    return (x >> 5) == (y >> 5);
  endfunction

  function automatic int m_coal(logic [ADDR_W-1:0] a);
`ifdef EWB_COALESCE_EN
    for (int i = q.size() - 1; i >= 0; i--)
      if (!(i == 0 && in_wr) && same_line(q[i].a, a)) return i;
`endif
    return -1;
  endfunction

  function automatic bit m_ready(logic [ADDR_W-1:0] a);
    return (q.size() < DEPTH) || (m_coal(a) >= 0);
  endfunction

  // One clock cycle: check outputs against the model, advance the model, reach the next negedge
  task automatic tick();
    int ci;
    bit pushok, start, pop;
    bit exp_hit;
    logic [LINE_W-1:0] exp_hd;
    #1;
    if (rst) begin
      chk("rst_pw", pmem_write, 0);
      chk("rst_rdy", evict_ready, 1);
      chk("rst_empty", empty, 1);
      chk("rst_cnt", count, 0);
      chk("rst_hit", rd_hit, 0);
    end else begin
      chk("cnt", count, q.size());
      chk("empty", empty, q.size() == 0);
      chk("rdy", evict_ready, m_ready(evict_addr));
      chk("pw", pmem_write, in_wr);
      if (in_wr && q.size() > 0) begin
        chk("paddr", pmem_address, q[0].a);
        chk("pdata", pmem_wdata, q[0].d);
      end
      exp_hit = 0;
      exp_hd  = '0;
      for (int i = q.size() - 1; i >= 0; i--)
        if (same_line(q[i].a, rd_addr)) begin
          exp_hit = 1;
          exp_hd  = q[i].d;
          break;
        end
      chk("hit", rd_hit, exp_hit);
      chk("hdata", rd_hit_data, exp_hd);
    end
    if (rst) begin
      q.delete();
      in_wr = 0;
    end else begin
      ci     = m_coal(evict_addr);
      pushok = evict_valid && ((q.size() < DEPTH) || ci >= 0);
      start  = !in_wr && q.size() > 0 && (!pmem_rd_busy || flush);
      pop    = in_wr && pmem_resp;
      if (pushok && ci >= 0) q[ci].d = evict_data;
      else if (pushok) q.push_back('{a: evict_addr, d: evict_data});
      if (pop) begin
        void'(q.pop_front());
        in_wr = 0;
      end
      if (start) in_wr = 1;
    end
    @(negedge clk);
  endtask

  task automatic push1(logic [ADDR_W-1:0] a, logic [LINE_W-1:0] d);
    evict_valid = 1'b1;
    evict_addr  = a;
    evict_data  = d;
    tick();
    evict_valid = 1'b0;
  endtask

  task automatic wait_pw(string tag);
    for (int i = 0; i < 4; i++) begin
      if (pmem_write) break;
      tick();
    end
    chk(tag, pmem_write, 1);
  endtask

  logic [ADDR_W-1:0] wr_a[$];
  logic [LINE_W-1:0] wr_d[$];

  // Acts as pmem: acknowledges every write immediately and logs it; bounded
  task automatic drain(string tag);
    wr_a.delete();
    wr_d.delete();
    for (int i = 0; i < 60; i++) begin
      if (empty && !pmem_write) break;
      #1;
      pmem_resp = pmem_write;
      if (pmem_write) begin
        wr_a.push_back(pmem_address);
        wr_d.push_back(pmem_wdata);
      end
      tick();
    end
    pmem_resp = 1'b0;
    chk(tag, empty, 1);
  endtask

  logic [ADDR_W-1:0] exp_a[$];
  logic [LINE_W-1:0] d1, d2;

  initial begin
    @(negedge clk);
    tick();
    tick();
    rd_addr = 32'h100;
    #1;
    chk("rst_hit0", rd_hit, 0);
    chk("rst_ready", evict_ready, 1);
    rst = 1'b0;

    // Single line: push, drain, empty
    push1(32'h100, 256'hAA);
    #1;
    chk("t1_cnt", count, 1);
    wait_pw("t1_pw");
    chk("t1_addr", pmem_address, 32'h100);
    chk("t1_data", pmem_wdata, 256'hAA);
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    chk("t1_empty", empty, 1);

    // Fill under pmem read busy, reject a 5th line, then drain in order
    pmem_rd_busy = 1'b1;
    exp_a = '{32'h1000, 32'h2000, 32'h3000, 32'h4000};
    foreach (exp_a[i]) begin
      push1(exp_a[i], {8{$urandom}});
      chk("t2_pw_idle", pmem_write, 0);
    end
    chk("t2_cnt", count, 4);
    chk("t2_rdy", evict_ready, 0);
    push1(32'h5000, 256'h55);
    chk("t2_cnt5", count, 4);
    chk("t2_pw", pmem_write, 0);
    pmem_rd_busy = 1'b0;
    drain("t3_empty");
    chk("t3_nwr", wr_a.size(), 4);
    foreach (exp_a[i]) chk("t3_order", (i < wr_a.size()) ? wr_a[i] : 32'hx, exp_a[i]);

`ifndef EWB_COALESCE_EN
    // Duplicate address: newest wins on forwarding
    pmem_rd_busy = 1'b1;
    d1 = {8{$urandom}};
    d2 = {8{$urandom}};
    push1(32'h200, d1);
    push1(32'h200, d2);
    rd_req  = 1'b1;
    rd_addr = 32'h200;
    #1;
    chk("t4_hit", rd_hit, 1);
    chk("t4_data", rd_hit_data, d2);
    rd_addr = 32'h240;
    #1;
    chk("t4_miss", rd_hit, 0);
    chk("t4_mdata", rd_hit_data, 0);
    rd_req = 1'b0;

    // Full buffer: pop and push in the same cycle rejects the push
    push1(32'h400, 256'h44);
    push1(32'h440, 256'h45);
    chk("t5_full", count, 4);
    pmem_rd_busy = 1'b0;
    wait_pw("t5_pw");
    pmem_resp   = 1'b1;
    evict_valid = 1'b1;
    evict_addr  = 32'h7000;
    evict_data  = 256'h77;
    #1;
    chk("t5_rdy0", evict_ready, 0);
    tick();
    pmem_resp = 1'b0;
    chk("t5_cnt3", count, 3);
    #1;
    chk("t5_rdy1", evict_ready, 1);
    tick();
    evict_valid = 1'b0;
    chk("t5_cnt4", count, 4);
    drain("t5_empty");
    exp_a = '{32'h200, 32'h400, 32'h440, 32'h7000};
    chk("t5_nwr", wr_a.size(), 4);
    foreach (exp_a[i]) chk("t5_order", (i < wr_a.size()) ? wr_a[i] : 32'hx, exp_a[i]);
    chk("t5_d2", (wr_d.size() > 0) ? wr_d[0] : 256'hx, d2);
`else
    // Coalescing: second push of the same line overwrites in place
    d1 = {8{$urandom}};
    d2 = {8{$urandom}};
    push1(32'h300, d1);
    pmem_rd_busy = 1'b1;
    push1(32'h300, d2);
    chk("c_cnt", count, 1);
    pmem_rd_busy = 1'b0;
    drain("c_empty");
    chk("c_nwr", wr_a.size(), 1);
    chk("c_data", (wr_d.size() > 0) ? wr_d[0] : 256'hx, d2);
`endif

    // Flush drains despite busy; reset mid-write abandons the line
    pmem_rd_busy = 1'b1;
    push1(32'h600, 256'h66);
    push1(32'h640, 256'h67);
    flush = 1'b1;
    drain("t6_empty");
    chk("t6_nwr", wr_a.size(), 2);
    push1(32'h800, 256'h88);
    wait_pw("t6_pw");
    rst = 1'b1;
    tick();
    chk("t6_rst_pw", pmem_write, 0);
    rst = 1'b0;
    tick();
    chk("t6_pw0", pmem_write, 0);
    chk("t6_cnt0", count, 0);
    flush = 1'b0;
    pmem_rd_busy = 1'b0;

    // Random traffic against the model; line pool is small to force address reuse
    for (int n = 0; n < 1500; n++) begin
      evict_addr   = 32'h2000 + ($urandom_range(0, 5) << 5) + $urandom_range(0, 31);
      evict_data   = {8{$urandom}};
      evict_valid  = ($urandom_range(0, 99) < 45) && m_ready(evict_addr);
      rd_addr      = 32'h2000 + ($urandom_range(0, 6) << 5) + $urandom_range(0, 31);
      rd_req       = $urandom_range(0, 1);
      pmem_rd_busy = $urandom_range(0, 99) < 35;
      flush        = $urandom_range(0, 99) < 10;
      pmem_resp    = $urandom_range(0, 1);
      rst          = $urandom_range(0, 199) == 0;
      tick();
    end
    evict_valid = 1'b0;
    rst = 1'b0;
    pmem_rd_busy = 1'b0;
    drain("rnd_empty");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
